// File: rtl/sa_ctrl_pkg.sv
// rtl/sa_ctrl_pkg.sv - state encoding and sizing helpers for the systolic array sequencer
package sa_ctrl_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    STREAM  = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // Cycles needed for the last injected column to ripple out of the array.
  function automatic int drain_cycles(input int pe_size);
    return 2 * pe_size - 1;
  endfunction

endpackage

// File: rtl/sa_en_align.sv
// rtl/sa_en_align.sv - delays a buffer read strobe by the 1-cycle read latency into an enable vector
module sa_en_align #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe,
  output logic [WIDTH-1:0] en
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en <= '0;
    end else begin
      en <= {WIDTH{strobe}};
    end
  end

endmodule

// File: rtl/sa_ctrl.sv
// rtl/sa_ctrl.sv - tile sequencer: ifmap preload, weight streaming, drain, done
// Optional cycle counter port perf_cycles_o enabled by defining SA_CTRL_PERF_EN.
module sa_ctrl
  import sa_ctrl_pkg::*;
#(
  parameter int PE_SIZE    = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [CNT_WIDTH-1:0]  k_len_i,
  input  logic [ADDR_WIDTH-1:0] ifmap_base_i,
  input  logic [ADDR_WIDTH-1:0] weight_base_i,
  output logic                  ifmap_rd_en_o,
  output logic [ADDR_WIDTH-1:0] ifmap_rd_addr_o,
  output logic                  weight_rd_en_o,
  output logic [ADDR_WIDTH-1:0] weight_rd_addr_o,
  output logic [PE_SIZE-1:0]    ifmap_en_row_o,
  output logic [PE_SIZE-1:0]    weight_en_col_o,
  output logic [PE_SIZE-1:0]    psum_en_row_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef SA_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_cycles_o
`endif
);

  localparam logic [CNT_WIDTH-1:0] PRELOAD_LAST = CNT_WIDTH'(PE_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0] DRAIN_LAST   = CNT_WIDTH'(drain_cycles(PE_SIZE) - 1);

  state_t                  state, state_n;
  logic [CNT_WIDTH-1:0]    cnt, cnt_n;
  logic [CNT_WIDTH-1:0]    k_len_q, k_len_n;
  logic [ADDR_WIDTH-1:0]   ifmap_base_q, ifmap_base_n;
  logic [ADDR_WIDTH-1:0]   weight_base_q, weight_base_n;
  logic                    ifmap_rd_en_n, weight_rd_en_n;
  logic [ADDR_WIDTH-1:0]   ifmap_rd_addr_n, weight_rd_addr_n;
  logic                    busy_n, done_n;
  logic [PE_SIZE-1:0]      weight_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cnt              <= '0;
      k_len_q          <= '0;
      ifmap_base_q     <= '0;
      weight_base_q    <= '0;
      ifmap_rd_en_o    <= 1'b0;
      ifmap_rd_addr_o  <= '0;
      weight_rd_en_o   <= 1'b0;
      weight_rd_addr_o <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      k_len_q          <= k_len_n;
      ifmap_base_q     <= ifmap_base_n;
      weight_base_q    <= weight_base_n;
      ifmap_rd_en_o    <= ifmap_rd_en_n;
      ifmap_rd_addr_o  <= ifmap_rd_addr_n;
      weight_rd_en_o   <= weight_rd_en_n;
      weight_rd_addr_o <= weight_rd_addr_n;
      busy_o           <= busy_n;
      done_o           <= done_n;
    end
  end

  // Outputs are decoded from the next state so they are registered yet land in that state's cycle.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    k_len_n       = k_len_q;
    ifmap_base_n  = ifmap_base_q;
    weight_base_n = weight_base_q;
    case (state)
      IDLE: begin
        if (start_i) begin
          k_len_n       = k_len_i;
          ifmap_base_n  = ifmap_base_i;
          weight_base_n = weight_base_i;
          cnt_n         = '0;
          state_n       = (k_len_i == '0) ? DONE : PRELOAD;
        end
      end
      PRELOAD: begin
        if (cnt == PRELOAD_LAST) begin
          cnt_n   = '0;
          state_n = STREAM;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STREAM: begin
        if (cnt == k_len_q - 1'b1) begin
          cnt_n   = '0;
          state_n = DRAIN;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          cnt_n   = '0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    ifmap_rd_en_n    = (state_n == PRELOAD);
    weight_rd_en_n   = (state_n == STREAM);
    ifmap_rd_addr_n  = ifmap_rd_en_n  ? ifmap_base_n  + ADDR_WIDTH'(cnt_n) : '0;
    weight_rd_addr_n = weight_rd_en_n ? weight_base_n + ADDR_WIDTH'(cnt_n) : '0;
    busy_n           = (state_n != IDLE);
    done_n           = (state_n == DONE);
  end

  sa_en_align #(.WIDTH(PE_SIZE)) u_ifmap_align (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (ifmap_rd_en_o),
    .en     (ifmap_en_row_o)
  );

  sa_en_align #(.WIDTH(PE_SIZE)) u_weight_align (
    .clk    (clk),
    .rst_n  (rst_n),
    .strobe (weight_rd_en_o),
    .en     (weight_en)
  );

  assign weight_en_col_o = weight_en;
  assign psum_en_row_o   = weight_en;

`ifdef SA_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_o <= '0;
    end else if (state == IDLE && start_i) begin
      perf_cycles_o <= '0;
    end else if (busy_o) begin
      perf_cycles_o <= perf_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sa_ctrl.sv
// tb/tb_sa_ctrl.sv - directed self-checking bench for sa_ctrl (PE_SIZE=2)
module tb_sa_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start_i;
  logic [7:0] k_len_i;
  logic [7:0] ifmap_base_i;
  logic [7:0] weight_base_i;
  logic       ifmap_rd_en_o;
  logic [7:0] ifmap_rd_addr_o;
  logic       weight_rd_en_o;
  logic [7:0] weight_rd_addr_o;
  logic [1:0] ifmap_en_row_o;
  logic [1:0] weight_en_col_o;
  logic [1:0] psum_en_row_o;
  logic       busy_o;
  logic       done_o;
`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_cycles_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic       c_ird  [0:31];
  logic [7:0] c_iad  [0:31];
  logic       c_wrd  [0:31];
  logic [7:0] c_wad  [0:31];
  logic [1:0] c_ien  [0:31];
  logic [1:0] c_wen  [0:31];
  logic [1:0] c_pen  [0:31];
  logic       c_busy [0:31];
  logic       c_done [0:31];

  sa_ctrl #(.PE_SIZE(2), .ADDR_WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start_i),
    .k_len_i          (k_len_i),
    .ifmap_base_i     (ifmap_base_i),
    .weight_base_i    (weight_base_i),
    .ifmap_rd_en_o    (ifmap_rd_en_o),
    .ifmap_rd_addr_o  (ifmap_rd_addr_o),
    .weight_rd_en_o   (weight_rd_en_o),
    .weight_rd_addr_o (weight_rd_addr_o),
    .ifmap_en_row_o   (ifmap_en_row_o),
    .weight_en_col_o  (weight_en_col_o),
    .psum_en_row_o    (psum_en_row_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
`ifdef SA_CTRL_PERF_EN
    ,
    .perf_cycles_o    (perf_cycles_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start (cycle 0), then record outputs mid-cycle for cycles 1..n.
  // Inputs are scrambled after the start edge; latched copies must be used.
  task automatic capture(input int n, input int s1, input int s2);
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i       = 1'b0;
    k_len_i       = 8'd7;
    ifmap_base_i  = 8'h55;
    weight_base_i = 8'h66;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      c_ird[c]  = ifmap_rd_en_o;
      c_iad[c]  = ifmap_rd_addr_o;
      c_wrd[c]  = weight_rd_en_o;
      c_wad[c]  = weight_rd_addr_o;
      c_ien[c]  = ifmap_en_row_o;
      c_wen[c]  = weight_en_col_o;
      c_pen[c]  = psum_en_row_o;
      c_busy[c] = busy_o;
      c_done[c] = done_o;
      start_i   = (c == s1 || c == s2);
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_i = 1'b0;
    k_len_i = '0;
    ifmap_base_i = '0;
    weight_base_i = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({ifmap_rd_en_o, weight_rd_en_o, busy_o, done_o} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset strobes got %b exp 0000", {ifmap_rd_en_o, weight_rd_en_o, busy_o, done_o});
    end
    n_cmp++;
    if ({ifmap_rd_addr_o, weight_rd_addr_o} !== 16'h0) begin
      n_bad++;
      $display("FAIL reset addrs got %h exp 0000", {ifmap_rd_addr_o, weight_rd_addr_o});
    end
    n_cmp++;
    if ({ifmap_en_row_o, weight_en_col_o, psum_en_row_o} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset enables got %b exp 000000", {ifmap_en_row_o, weight_en_col_o, psum_en_row_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic       e_ird, e_wrd, e_busy, e_done;
    logic [7:0] e_iad, e_wad;
    logic [1:0] e_ien, e_wen;
    k_len_i = 8'd3;
    ifmap_base_i = 8'h10;
    weight_base_i = 8'h20;
    capture(12, -1, -1);
    for (int c = 1; c <= 12; c++) begin
      e_ird  = (c >= 1 && c <= 2);
      e_iad  = e_ird ? 8'(8'h10 + c - 1) : 8'h00;
      e_ien  = (c >= 2 && c <= 3) ? 2'b11 : 2'b00;
      e_wrd  = (c >= 3 && c <= 5);
      e_wad  = e_wrd ? 8'(8'h20 + c - 3) : 8'h00;
      e_wen  = (c >= 4 && c <= 6) ? 2'b11 : 2'b00;
      e_busy = (c >= 1 && c <= 9);
      e_done = (c == 9);
      n_cmp++;
      if (c_ird[c] !== e_ird) begin
        n_bad++; $display("FAIL basic c=%0d ifmap_rd_en got %b exp %b", c, c_ird[c], e_ird);
      end
      n_cmp++;
      if (c_iad[c] !== e_iad) begin
        n_bad++; $display("FAIL basic c=%0d ifmap_rd_addr got %h exp %h", c, c_iad[c], e_iad);
      end
      n_cmp++;
      if (c_ien[c] !== e_ien) begin
        n_bad++; $display("FAIL basic c=%0d ifmap_en_row got %b exp %b", c, c_ien[c], e_ien);
      end
      n_cmp++;
      if (c_wrd[c] !== e_wrd) begin
        n_bad++; $display("FAIL basic c=%0d weight_rd_en got %b exp %b", c, c_wrd[c], e_wrd);
      end
      n_cmp++;
      if (c_wad[c] !== e_wad) begin
        n_bad++; $display("FAIL basic c=%0d weight_rd_addr got %h exp %h", c, c_wad[c], e_wad);
      end
      n_cmp++;
      if (c_wen[c] !== e_wen || c_pen[c] !== e_wen) begin
        n_bad++; $display("FAIL basic c=%0d weight/psum en got %b/%b exp %b", c, c_wen[c], c_pen[c], e_wen);
      end
      n_cmp++;
      if (c_busy[c] !== e_busy) begin
        n_bad++; $display("FAIL basic c=%0d busy got %b exp %b", c, c_busy[c], e_busy);
      end
      n_cmp++;
      if (c_done[c] !== e_done) begin
        n_bad++; $display("FAIL basic c=%0d done got %b exp %b", c, c_done[c], e_done);
      end
    end
`ifdef SA_CTRL_PERF_EN
    n_cmp++;
    if (perf_cycles_o !== 32'd9) begin
      n_bad++; $display("FAIL perf_cycles got %0d exp 9", perf_cycles_o);
    end
`endif
  endtask

  task automatic test_zero_len();
    k_len_i = 8'd0;
    ifmap_base_i = 8'h10;
    weight_base_i = 8'h20;
    capture(6, -1, -1);
    for (int c = 1; c <= 6; c++) begin
      n_cmp++;
      if ({c_ird[c], c_wrd[c], c_ien[c], c_wen[c], c_pen[c]} !== 8'b0) begin
        n_bad++;
        $display("FAIL zero_len c=%0d reads/enables got %b exp 0", c, {c_ird[c], c_wrd[c], c_ien[c], c_wen[c], c_pen[c]});
      end
      n_cmp++;
      if (c_busy[c] !== (c == 1) || c_done[c] !== (c == 1)) begin
        n_bad++;
        $display("FAIL zero_len c=%0d busy/done got %b%b exp %b%b", c, c_busy[c], c_done[c], c == 1, c == 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e_busy, e_ird;
    k_len_i = 8'd3;
    ifmap_base_i = 8'h10;
    weight_base_i = 8'h20;
    capture(14, 4, 10);
    for (int c = 1; c <= 14; c++) begin
      e_busy = (c <= 9) || (c >= 11);
      e_ird  = (c == 1 || c == 2 || c == 11 || c == 12);
      n_cmp++;
      if (c_done[c] !== (c == 9)) begin
        n_bad++; $display("FAIL b2b c=%0d done got %b exp %b", c, c_done[c], c == 9);
      end
      n_cmp++;
      if (c_busy[c] !== e_busy) begin
        n_bad++; $display("FAIL b2b c=%0d busy got %b exp %b", c, c_busy[c], e_busy);
      end
      n_cmp++;
      if (c_ird[c] !== e_ird) begin
        n_bad++; $display("FAIL b2b c=%0d ifmap_rd_en got %b exp %b", c, c_ird[c], e_ird);
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_addr_wrap();
    logic [7:0] exp_addr [0:2];
    exp_addr[0] = 8'hFE;
    exp_addr[1] = 8'hFF;
    exp_addr[2] = 8'h00;
    k_len_i = 8'd3;
    ifmap_base_i = 8'h00;
    weight_base_i = 8'hFE;
    capture(10, -1, -1);
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (c_wrd[3 + j] !== 1'b1 || c_wad[3 + j] !== exp_addr[j]) begin
        n_bad++;
        $display("FAIL wrap j=%0d weight en/addr got %b/%h exp 1/%h", j, c_wrd[3 + j], c_wad[3 + j], exp_addr[j]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int seen_done;
    k_len_i = 8'd3;
    ifmap_base_i = 8'h10;
    weight_base_i = 8'h20;
    @(negedge clk);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({weight_rd_en_o, busy_o, done_o, weight_en_col_o, psum_en_row_o} !== 7'b0) begin
      n_bad++;
      $display("FAIL mid_reset outputs got %b exp 0", {weight_rd_en_o, busy_o, done_o, weight_en_col_o, psum_en_row_o});
    end
    n_cmp++;
    if (weight_rd_addr_o !== 8'h00) begin
      n_bad++; $display("FAIL mid_reset weight_rd_addr got %h exp 00", weight_rd_addr_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done_o === 1'b1 || busy_o === 1'b1) seen_done++;
    end
    n_cmp++;
    if (seen_done !== 0) begin
      n_bad++; $display("FAIL mid_reset idle after reset busy/done cycles got %0d exp 0", seen_done);
    end
    k_len_i = 8'd3;
    ifmap_base_i = 8'h10;
    weight_base_i = 8'h20;
    capture(12, -1, -1);
    for (int c = 1; c <= 12; c++) begin
      n_cmp++;
      if (c_done[c] !== (c == 9)) begin
        n_bad++; $display("FAIL mid_reset rerun c=%0d done got %b exp %b", c, c_done[c], c == 9);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_back_to_back();
    test_addr_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sa_ctrl.md
Name: sa_ctrl

Overview:
- Sequencer for the PE_SIZE x PE_SIZE systolic array (SA).
- Runs one tile operation per start pulse, in this order:
  - ifmap preload, PE_SIZE rows.
  - Weight-column streaming, k_len columns, with psum injection enabled.
  - Drain.
- Drives the SA enable vectors directly and issues read addresses to the ifmap and weight buffers. Both buffers have a fixed 1-cycle read latency.
- Psum data into the SA is tied to zero outside this block. This block drives only the psum enables.

Parameters:
- PE_SIZE, 2, array dimension; also the width of each enable vector.
- ADDR_WIDTH, 8, buffer address width.
- CNT_WIDTH, 8, width of k_len and the internal counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle request; sampled only in IDLE.
- k_len_i  in  CNT_WIDTH  number of weight columns to stream.
- ifmap_base_i  in  ADDR_WIDTH  first ifmap buffer address.
- weight_base_i  in  ADDR_WIDTH  first weight buffer address.
- ifmap_rd_en_o  out  1  ifmap buffer read strobe.
- ifmap_rd_addr_o  out  ADDR_WIDTH  ifmap read address.
- weight_rd_en_o  out  1  weight buffer read strobe.
- weight_rd_addr_o  out  ADDR_WIDTH  weight read address.
- ifmap_en_row_o  out  PE_SIZE  SA ifmap_en_row_i.
- weight_en_col_o  out  PE_SIZE  SA weight_en_col_i.
- psum_en_row_o  out  PE_SIZE  SA psum_en_row_i.
- busy_o  out  1  high from the cycle after an accepted start through the DONE cycle.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE and all counters are 0. Reset is asynchronous, so asserting rst_n mid-operation aborts immediately and no done_o is produced.
- All outputs are registered.
- FSM states: IDLE, PRELOAD, STREAM, DRAIN, DONE.
- IDLE:
  - On start_i, latch k_len_i, ifmap_base_i and weight_base_i.
  - If k_len_i != 0, go to PRELOAD.
  - If k_len_i == 0, go to DONE: done_o pulses with no enables or reads issued.
- PRELOAD (PE_SIZE cycles):
  - ifmap_rd_en_o = 1 and ifmap_rd_addr_o = base + i, for i = 0 .. PE_SIZE-1.
  - Then go to STREAM.
- STREAM (k_len cycles):
  - weight_rd_en_o = 1 and weight_rd_addr_o = weight base + j.
  - Then go to DRAIN.
- DRAIN (2*PE_SIZE-1 cycles): no reads issued. Then go to DONE.
- DONE (1 cycle): done_o = 1, then return to IDLE. busy_o is high in PRELOAD, STREAM, DRAIN and DONE.
- Buffer-latency alignment:
  - ifmap_en_row_o = all-ones exactly one cycle after each ifmap_rd_en_o.
  - weight_en_col_o and psum_en_row_o = all-ones exactly one cycle after each weight_rd_en_o, so they overlap the first DRAIN cycle.
  - Otherwise these vectors are all-zeros.
- start_i outside IDLE is ignored. No queueing.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Input changes after start are ignored until the next IDLE.
- Counters compare against the latched value minus 1. No counter overflows for k_len up to 2^CNT_WIDTH-1.

Optional Feature:
- Macro: SA_CTRL_PERF_EN.
- With the macro defined:
  - Adds output perf_cycles_o [31:0].
  - The counter clears on an accepted start and increments every busy_o cycle.
  - It holds its value after done_o. Its reset value is 0.
- Without the macro: the port and counter are absent, with no other change.

Decomposition:
- Package sa_ctrl_pkg holds:
  - The state encoding localparams (IDLE=0, PRELOAD=1, STREAM=2, DRAIN=3, DONE=4, 3-bit).
  - A constant function drain_cycles(PE_SIZE) = 2*PE_SIZE-1.
- One sub-module, sa_en_align: a parameterised 1-cycle delay register that turns a read strobe into an all-ones enable vector, with async reset. It is instantiated twice (ifmap path, weight/psum path).

Test Plan (PE_SIZE=2; the cycle n at which start_i=1 is sampled counts as cycle 0):
- Basic run: k_len=3, ifmap base 0x10, weight base 0x20.
  - ifmap_rd_en_o at cycles 1-2, addresses 0x10, 0x11; ifmap_en_row_o = 2'b11 at cycles 2-3.
  - weight reads at cycles 3-5, addresses 0x20-0x22; weight_en_col_o = psum_en_row_o = 2'b11 at cycles 4-6.
  - done_o at cycle 9; busy_o high cycles 1-9.
- k_len=0: done_o at cycle 1; no read strobes or enables ever asserted; busy_o high only at cycle 1.
- start_i pulsed again at cycle 4 of a run: ignored, and the cycle-9 done_o is unchanged. A start at cycle 10 launches a new run.
- Address wrap: weight base 0xFE, k_len=3 -> weight addresses 0xFE, 0xFF, 0x00.
- Mid-run reset: rst_n low at cycle 4 -> all outputs 0 immediately, FSM in IDLE, no done_o. A new start after release completes normally.
- With SA_CTRL_PERF_EN, run 1: perf_cycles_o = 9 after done_o.
